pe_switch_ctx_sequencer: RTL and testbench
==========================================

Name: pe_switch_ctx_sequencer

Overview:
Produces the 8-bit per-PE `switch` word that the PE 4x4 crossbar consumes, one value per cycle.
- Accepts NUM_CTX switch bytes over a valid/ready config stream into a local context memory.
- On command, replays the contexts cyclically for a programmed number of iterations, then returns to an identity route.
- Sits between the array config loader and each PE's crossbar.
- Flags configurations that are not permutations, since the crossbar's priority mux silently drops those routes.

Parameters:
- NUM_CTX, 4, number of context entries (power of two, >=2).
- CTX_W, 2, log2(NUM_CTX); width of ctx_idx and the write pointer.
- ITER_W, 16, width of run_iters and the iteration counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load_start  input  1  begin loading NUM_CTX context bytes.
- cfg_valid  input  1  config byte valid.
- cfg_data  input  8  switch byte {N_sel[7:6],S_sel[5:4],W_sel[3:2],E_sel[1:0]}; sel code 00=N, 01=S, 10=W, 11=E destination.
- cfg_ready  output  1  block accepts a config byte.
- run_start  input  1  begin replay.
- run_iters  input  ITER_W  full passes over all contexts; sampled on the run_start accept cycle.
- abort  input  1  return to IDLE.
- switch  output  8  registered crossbar control.
- ctx_idx  output  CTX_W  context index currently driven on switch.
- busy  output  1  high in LOAD or RUN.
- done  output  1  one-cycle pulse when a run completes.
- cfg_conflict  output  1  sticky: a loaded byte had duplicate destination codes.

Behaviour:
- States: IDLE, LOAD, READY, RUN.
- Reset (rst_n=0 at clk edge), from any state including mid-load or mid-run:
  - state=IDLE; switch=8'h1B (identity: N->N, S->S, W->W, E->E).
  - ctx_idx=0, cfg_ready=0, busy=0, done=0, cfg_conflict=0; counters=0.
  - Context memory contents undefined and not reset.
- IDLE: cfg_ready=0, switch=8'h1B. load_start -> LOAD next cycle, write pointer=0, cfg_conflict cleared. run_start ignored.
- LOAD:
  - cfg_ready=1. A byte transfers on clk edge when cfg_valid&&cfg_ready and is written to mem[wr_ptr]; wr_ptr increments.
  - Transfer with wr_ptr==NUM_CTX-1 -> READY next cycle; cfg_ready drops in the same cycle as the transition.
  - cfg_valid gaps are allowed. run_start and load_start are ignored. switch holds 8'h1B.
- Conflict check, on every transferred byte: if any two of the four 2-bit fields are equal, cfg_conflict sets. It stays set until load_start or reset. The byte is stored anyway.
- READY:
  - switch=8'h1B, busy=0.
  - load_start -> LOAD (reload). load_start wins if asserted with run_start in the same cycle.
  - run_start with run_iters==0 -> done=1 for the next cycle; state stays READY.
  - run_start with run_iters>0 -> RUN; iter_cnt=0, ctx=0.
- RUN:
  - switch/ctx_idx are registered: the first cycle in RUN shows mem[0]/0. Latency is 1 cycle from run_start to first context.
  - Each cycle ctx increments. On ctx==NUM_CTX-1 it wraps to 0 and iter_cnt increments.
  - On ctx==NUM_CTX-1 && iter_cnt==run_iters-1:
    - next state READY, switch=8'h1B, ctx_idx=0.
    - done=1 in that first READY cycle.
  - Total RUN cycles = NUM_CTX*run_iters exactly.
  - run_start and load_start are ignored in RUN. run_iters changes after the accept cycle have no effect.
- abort, any state except when overridden by reset: next cycle IDLE, switch=8'h1B, cfg_ready=0, no done pulse.
  - Memory is retained but a new load_start is required before the next run.
  - abort has priority over load_start/run_start in the same cycle.
- done is asserted only as specified above and never for 2 consecutive cycles.

Test Plan:
1. Reset, then idle 5 cycles -> switch=8'h1B, ctx_idx=0, cfg_ready=0, busy=0, done=0.
2. load_start; send 8'h1B,8'h4E,8'hB1,8'hE4 with one idle gap after the 2nd byte; run_start with run_iters=2 -> 8 consecutive RUN cycles with switch=1B,4E,B1,E4,1B,4E,B1,E4 and ctx_idx=0,1,2,3,0,1,2,3. Then switch=8'h1B with done=1 for exactly one cycle; cfg_conflict=0.
3. Load 8'h1B,8'h00,8'h1B,8'h1B -> cfg_conflict=1 after the 2nd byte, remains 1 in READY. A new load_start clears it to 0.
4. READY, run_start with run_iters=0 -> no RUN cycles, switch stays 8'h1B, done=1 next cycle. Simultaneous load_start+run_start -> enters LOAD, cfg_ready=1.
5. RUN with run_iters=3, abort on the 6th RUN cycle -> next cycle IDLE, switch=8'h1B, no done. A following run_start is ignored until reload.
6. rst_n=0 for one cycle after 2 of 4 bytes loaded -> IDLE, cfg_ready=0. A fresh load of 4 bytes plus run_iters=1 -> correct 4-cycle sequence.

Source files
------------

// File: rtl/pe_switch_ctx_sequencer.sv
// Per-PE crossbar context sequencer.
// Loads NUM_CTX switch bytes over a valid/ready stream, then replays them
// cyclically for a programmed number of passes before returning to the
// identity route. Flags loaded bytes whose destination codes are not a
// permutation, because the crossbar priority mux drops duplicate routes.
module pe_switch_ctx_sequencer #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2,
  parameter int ITER_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_data,
  output logic              cfg_ready,
  input  logic              run_start,
  input  logic [ITER_W-1:0] run_iters,
  input  logic              abort,
  output logic [7:0]        switch,
  output logic [CTX_W-1:0]  ctx_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_conflict
);

  localparam logic [7:0]       IDENT    = 8'h1B;
  localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CTX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        mem [NUM_CTX];
  logic [CTX_W-1:0]  wr_ptr;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W-1:0] iters;

  logic              xfer;
  logic              run_last;
  logic [7:0]        switch_nxt;
  logic [CTX_W-1:0]  ctx_nxt;
  logic              done_nxt;
  logic              cfg_ready_nxt;
  logic              busy_nxt;

  // Any two destination fields equal means the byte is not a permutation.
  function automatic logic has_dup(input logic [7:0] b);
    return (b[7:6] == b[5:4]) || (b[7:6] == b[3:2]) || (b[7:6] == b[1:0]) ||
           (b[5:4] == b[3:2]) || (b[5:4] == b[1:0]) || (b[3:2] == b[1:0]);
  endfunction

  assign xfer     = cfg_ready && cfg_valid;
  assign run_last = (state == RUN) && (ctx_idx == LAST_CTX) &&
                    (iter_cnt == (iters - ITER_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; abort overrides every other request.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) next_state = LOAD;
          else            next_state = IDLE;
        end
        LOAD: begin
          if (xfer && (wr_ptr == LAST_CTX)) next_state = READY;
          else                              next_state = LOAD;
        end
        READY: begin
          if (load_start)                                   next_state = LOAD;
          else if (run_start && (run_iters != ITER_W'(0)))  next_state = RUN;
          else                                              next_state = READY;
        end
        RUN: begin
          if (run_last) next_state = READY;
          else          next_state = RUN;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode: values the registered outputs take on the next edge.
  always_comb begin
    switch_nxt    = IDENT;
    ctx_nxt       = '0;
    if (next_state == RUN) begin
      if (state == RUN) ctx_nxt = ctx_idx + CTX_W'(1);
      else              ctx_nxt = '0;
      switch_nxt = mem[ctx_nxt];
    end else begin
      switch_nxt = IDENT;
    end
    // A zero-pass run completes immediately; done is never held two cycles.
    done_nxt      = !done && !abort &&
                    (run_last ||
                     ((state == READY) && run_start && !load_start &&
                      (run_iters == ITER_W'(0))));
    cfg_ready_nxt = (next_state == LOAD);
    busy_nxt      = (next_state == LOAD) || (next_state == RUN);
  end

  // Registered outputs plus load/iteration bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      switch       <= IDENT;
      ctx_idx      <= '0;
      done         <= 1'b0;
      cfg_ready    <= 1'b0;
      busy         <= 1'b0;
      cfg_conflict <= 1'b0;
      wr_ptr       <= '0;
      iter_cnt     <= '0;
      iters        <= '0;
    end else begin
      switch    <= switch_nxt;
      ctx_idx   <= ctx_nxt;
      done      <= done_nxt;
      cfg_ready <= cfg_ready_nxt;
      busy      <= busy_nxt;
      if ((state == IDLE || state == READY) && (next_state == LOAD)) begin
        wr_ptr       <= '0;
        cfg_conflict <= 1'b0;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + CTX_W'(1);
        if (has_dup(cfg_data)) cfg_conflict <= 1'b1;
      end
      if ((state == READY) && (next_state == RUN)) begin
        iter_cnt <= '0;
        iters    <= run_iters;
      end else if ((state == RUN) && (ctx_idx == LAST_CTX)) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
      end
    end
  end

  // Context memory; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_ptr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_pe_switch_ctx_sequencer.sv
// Self-checking bench for pe_switch_ctx_sequencer with a behavioural model.
module tb_pe_switch_ctx_sequencer;

  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;
  localparam int ITER_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [7:0]        cfg_data = 8'h00;
  logic              cfg_ready;
  logic              run_start = 1'b0;
  logic [ITER_W-1:0] run_iters = '0;
  logic              abort = 1'b0;
  logic [7:0]        switch;
  logic [CTX_W-1:0]  ctx_idx;
  logic              busy;
  logic              done;
  logic              cfg_conflict;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat       [NUM_CTX];
  logic [7:0] mem_model [NUM_CTX];

  pe_switch_ctx_sequencer #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .run_start(run_start),
    .run_iters(run_iters), .abort(abort), .switch(switch), .ctx_idx(ctx_idx),
    .busy(busy), .done(done), .cfg_conflict(cfg_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A byte is a valid route only if each destination code appears once.
  function automatic logic has_dup(input logic [7:0] b);
    int cnt [4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 4; i++) cnt[b[2*i +: 2]]++;
    for (int i = 0; i < 4; i++) if (cnt[i] > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_perm();
    logic [1:0] codes [4];
    logic [1:0] t;
    int j;
    for (int i = 0; i < 4; i++) codes[i] = 2'(i);
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = codes[i]; codes[i] = codes[j]; codes[j] = t;
    end
    return {codes[0], codes[1], codes[2], codes[3]};
  endfunction

  // Load pat[] with an idle gap before byte i when gaps[i] is set.
  task automatic load_seq(input logic [3:0] gaps);
    logic exp_conf;
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++;
    if ({cfg_ready, busy, cfg_conflict, switch} !== {3'b110, 8'h1B}) begin
      errors++;
      $display("FAIL load_enter: got rdy/busy/conf/sw=%b%b%b/%h required 110/1b",
               cfg_ready, busy, cfg_conflict, switch);
    end
    exp_conf = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (gaps[i]) begin
        cfg_valid = 1'b0; tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_gap: cfg_ready=%b required 1", cfg_ready);
        end
      end
      cfg_valid = 1'b1; cfg_data = pat[i]; tick();
      cfg_valid = 1'b0; cfg_data = 8'($urandom);
      exp_conf = exp_conf | has_dup(pat[i]);
      checks++;
      if ({cfg_ready, cfg_conflict} !== {(i != NUM_CTX - 1), exp_conf}) begin
        errors++;
        $display("FAIL load_byte%0d: rdy/conf=%b%b required %b%b", i,
                 cfg_ready, cfg_conflict, (i != NUM_CTX - 1), exp_conf);
      end
    end
    for (int i = 0; i < NUM_CTX; i++) mem_model[i] = pat[i];
  endtask

  // Start a run from READY; abort on RUN cycle index abort_at (or never if <0).
  task automatic run_check(input int iters, input int abort_at);
    int total;
    logic [CTX_W-1:0] exp_idx;
    run_start = 1'b1; run_iters = ITER_W'(iters); tick();
    run_start = 1'b0; run_iters = 16'($urandom);
    total = iters * NUM_CTX;
    for (int k = 0; k < total; k++) begin
      exp_idx = CTX_W'(k % NUM_CTX);
      checks++;
      if ({switch, ctx_idx, busy, done} !== {mem_model[k % NUM_CTX], exp_idx, 2'b10}) begin
        errors++;
        $display("FAIL run_cycle%0d: sw/idx/busy/done=%h/%0d/%b/%b required %h/%0d/1/0",
                 k, switch, ctx_idx, busy, done, mem_model[k % NUM_CTX], exp_idx);
      end
      if (k == abort_at) begin
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if ({switch, ctx_idx, busy, done, cfg_ready} !== {8'h1B, 2'd0, 3'b000}) begin
          errors++;
          $display("FAIL abort_idle: sw/idx/busy/done/rdy=%h/%0d/%b/%b/%b required 1b/0/0/0/0",
                   switch, ctx_idx, busy, done, cfg_ready);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
          errors++;
          $display("FAIL abort_nodone: done/busy=%b%b required 00", done, busy);
        end
        return;
      end
      // Requests during RUN must be ignored.
      load_start = ($urandom_range(3, 0) == 0);
      run_start  = ($urandom_range(3, 0) == 0);
      tick();
      load_start = 1'b0; run_start = 1'b0;
    end
    checks++;
    if ({switch, ctx_idx, busy, done} !== {8'h1B, 2'd0, 2'b01}) begin
      errors++;
      $display("FAIL run_done: sw/idx/busy/done=%h/%0d/%b/%b required 1b/0/0/1",
               switch, ctx_idx, busy, done);
    end
    tick();
    checks++;
    if ({switch, busy, done, cfg_ready} !== {8'h1B, 3'b000}) begin
      errors++;
      $display("FAIL run_after: sw/busy/done/rdy=%h/%b/%b/%b required 1b/0/0/0",
               switch, busy, done, cfg_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_start = (i == 2);
      tick();
      run_start = 1'b0;
      checks++;
      if ({switch, ctx_idx, cfg_ready, busy, done, cfg_conflict} !== {8'h1B, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_idle%0d: sw/idx/rdy/busy/done/conf=%h/%0d/%b%b%b%b required 1b/0/0000",
                 i, switch, ctx_idx, cfg_ready, busy, done, cfg_conflict);
      end
    end
  endtask

  task automatic test_basic_run();
    pat[0] = 8'h1B; pat[1] = 8'h4E; pat[2] = 8'hB1; pat[3] = 8'hE4;
    load_seq(4'b0100);
    run_check(2, -1);
    checks++;
    if (cfg_conflict !== 1'b0) begin
      errors++;
      $display("FAIL basic_conflict: cfg_conflict=%b required 0", cfg_conflict);
    end
  endtask

  task automatic test_conflict();
    pat[0] = 8'h1B; pat[1] = 8'h00; pat[2] = 8'h1B; pat[3] = 8'h1B;
    load_seq(4'b0000);
    tick();
    checks++;
    if ({cfg_conflict, busy} !== 2'b10) begin
      errors++;
      $display("FAIL conflict_ready: conf/busy=%b%b required 10", cfg_conflict, busy);
    end
    for (int i = 0; i < NUM_CTX; i++) pat[i] = rand_perm();
    load_seq(4'b0000);
  endtask

  task automatic test_zero_iters();
    run_start = 1'b1; run_iters = '0; tick(); run_start = 1'b0;
    checks++;
    if ({switch, busy, done} !== {8'h1B, 2'b01}) begin
      errors++;
      $display("FAIL zero_done: sw/busy/done=%h/%b/%b required 1b/0/1", switch, busy, done);
    end
    tick();
    checks++;
    if ({switch, busy, done} !== {8'h1B, 2'b00}) begin
      errors++;
      $display("FAIL zero_after: sw/busy/done=%h/%b/%b required 1b/0/0", switch, busy, done);
    end
    for (int i = 0; i < NUM_CTX; i++) pat[i] = rand_perm();
    load_start = 1'b1; run_start = 1'b1; run_iters = 16'd2; tick();
    load_start = 1'b0; run_start = 1'b0;
    checks++;
    if ({cfg_ready, busy, switch} !== {2'b11, 8'h1B}) begin
      errors++;
      $display("FAIL load_wins: rdy/busy/sw=%b%b/%h required 11/1b", cfg_ready, busy, switch);
    end
    for (int i = 0; i < NUM_CTX; i++) begin
      cfg_valid = 1'b1; cfg_data = pat[i]; tick();
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) mem_model[i] = pat[i];
    run_check(1, -1);
  endtask

  task automatic test_abort();
    run_check(3, 5);
    run_start = 1'b1; run_iters = 16'd2; tick(); run_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({switch, busy, done} !== {8'h1B, 2'b00}) begin
        errors++;
        $display("FAIL abort_norun%0d: sw/busy/done=%h/%b/%b required 1b/0/0",
                 i, switch, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1; tick(); load_start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h00; tick();
    cfg_data = 8'h1B; tick(); cfg_valid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if ({switch, ctx_idx, cfg_ready, busy, done, cfg_conflict} !== {8'h1B, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_midload: sw/idx/rdy/busy/done/conf=%h/%0d/%b%b%b%b required 1b/0/0000",
               switch, ctx_idx, cfg_ready, busy, done, cfg_conflict);
    end
    for (int i = 0; i < NUM_CTX; i++) pat[i] = rand_perm();
    load_seq(4'b0000);
    run_check(1, -1);
  endtask

  task automatic test_random();
    int iters;
    int ab;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if ($urandom_range(1, 0) == 1) pat[i] = rand_perm();
        else                           pat[i] = 8'($urandom);
      end
      load_seq(4'($urandom));
      iters = int'($urandom_range(4, 1));
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(iters * NUM_CTX - 1, 0)) : -1;
      run_check(iters, ab);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_conflict();
    test_zero_iters();
    test_abort();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
